register_file: RTL and testbench

Parametrised multi-port register bank, the successor to the single 32-bit `REGISTER` storage element. It holds N words of M bits with one byte-maskable write port, READ_PORTS asynchronous read ports and optional write-to-read forwarding. It sits in the processor datapath as the architectural register file between decode and execute.

---
 rtl/register_file_pkg.sv | 27 ++
 rtl/register_file_if.sv | 19 +
 rtl/register_file_read_port.sv | 34 +++
 rtl/register_file.sv | 63 ++++++
 tb/tb_register_file.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// byte_merge works at MAX_WORD_W; callers size-cast to their own word width M.
package register_file_pkg;

    localparam int BYTE_W         = 8;
    localparam int MAX_READ_PORTS = 4;
    localparam int MAX_WORD_W     = 256;
    localparam int MAX_BYTES      = MAX_WORD_W / BYTE_W;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_WORD_W-1:0] byte_merge(
        input logic [MAX_WORD_W-1:0] old_word,
        input logic [MAX_WORD_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register file; the datapath drives it as master.
interface register_file_if import register_file_pkg::*; #(
    parameter int M          = 32,
    parameter int N          = 16,
    parameter int READ_PORTS = 2
) ();
    localparam int A = addr_width(N);

    logic                    CLR;
    logic                    WE;
    logic [A-1:0]            WA;
    logic [M/BYTE_W-1:0]     BE;
    logic [M-1:0]            DATA_IN;
    logic [READ_PORTS*A-1:0] RA;
    logic [READ_PORTS*M-1:0] RD;

    modport master (output CLR, WE, WA, BE, DATA_IN, RA, input RD);
    modport slave  (input CLR, WE, WA, BE, DATA_IN, RA, output RD);
endinterface

// File: rtl/register_file_read_port.sv
// One asynchronous read port: range check, zero-register mask, storage mux
// and same-cycle forwarding of the pending byte-merged write.
module regfile_read_port #(
    parameter int M        = 32,
    parameter int N        = 16,
    parameter int A        = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [A-1:0] ra,
    input  logic [M-1:0] mem [N],
    input  logic         wr_valid,
    input  logic         clr,
    input  logic [A-1:0] wa,
    input  logic [M-1:0] wr_merged,
    output logic [M-1:0] rd
);
    logic in_range;
    logic zero_hit;
    logic fwd_hit;

    assign in_range = int'(ra) < N;
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign fwd_hit  = (BYPASS != 0) && wr_valid && (ra == wa);

    always_comb begin
        rd = '0;
        if (in_range && !zero_hit) begin
            // a clear in the same cycle wins over the forwarded write data
            if (fwd_hit) rd = clr ? '0 : wr_merged;
            else         rd = mem[ra];
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural register file: N words of M bits, one byte-maskable write
// port, READ_PORTS combinational read ports with optional write forwarding.
module register_file import register_file_pkg::*; #(
    parameter int M          = 32,
    parameter int N          = 16,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input logic            clk,
    input logic            reset,
    register_file_if.slave bus
);
    localparam int A = addr_width(N);

    logic [M-1:0] mem [N];
    logic [M-1:0] rd_word [READ_PORTS];
    logic         wr_in_range;
    logic         wr_zero;
    logic         wr_valid;
    logic [M-1:0] wr_merged;

    assign wr_in_range = int'(bus.WA) < N;
    assign wr_zero     = (ZERO_REG != 0) && (bus.WA == '0);
    assign wr_valid    = reset && bus.WE && wr_in_range && !wr_zero;
    assign wr_merged   = M'(byte_merge(MAX_WORD_W'(mem[bus.WA]),
                                       MAX_WORD_W'(bus.DATA_IN),
                                       MAX_BYTES'(bus.BE)));

    // priority: async reset, then synchronous clear, then the write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (bus.CLR) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wr_valid) begin
            mem[bus.WA] <= wr_merged;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .M        (M),
            .N        (N),
            .A        (A),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_read_port (
            .ra        (bus.RA[p*A +: A]),
            .mem       (mem),
            .wr_valid  (wr_valid),
            .clr       (bus.CLR),
            .wa        (bus.WA),
            .wr_merged (wr_merged),
            .rd        (rd_word[p])
        );
    end

    always_comb begin
        bus.RD = '0;
        for (int p = 0; p < READ_PORTS; p++) bus.RD[p*M +: M] = rd_word[p];
    end
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: dut_a uses bypass with 16 regs / 2 ports,
// dut_b uses no bypass, a hardwired r0, 12 regs and 4 ports.
module tb_register_file;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_if #(.M(32), .N(16), .READ_PORTS(2)) bus_a ();
    register_file_if #(.M(32), .N(12), .READ_PORTS(4)) bus_b ();

    register_file #(.M(32), .N(16), .READ_PORTS(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    register_file #(.M(32), .N(12), .READ_PORTS(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          q_dut [$];
    int          q_port [$];
    logic [31:0] q_exp [$];
    string       q_tag [$];

    function automatic logic [31:0] rd_of(input int d, input int p);
        if (d == 0) return bus_a.RD[p*32 +: 32];
        return bus_b.RD[p*32 +: 32];
    endfunction

    task automatic expect_rd(input int d, input int p, input logic [31:0] v, input string tag);
        q_dut.push_back(d);
        q_port.push_back(p);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    task automatic check_sb();
        int          d;
        int          p;
        logic [31:0] exp_v;
        logic [31:0] obs;
        string       tag;
        #1;
        while (q_exp.size() > 0) begin
            d     = q_dut.pop_front();
            p     = q_port.pop_front();
            exp_v = q_exp.pop_front();
            tag   = q_tag.pop_front();
            obs   = rd_of(d, p);
            n_checks++;
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s dut%0d port%0d observed=%h expected=%h", tag, d, p, obs, exp_v);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] din, input logic clr);
        bus_a.WE = we;  bus_a.WA = wa;  bus_a.BE = be;  bus_a.DATA_IN = din;  bus_a.CLR = clr;
        bus_b.WE = we;  bus_b.WA = wa;  bus_b.BE = be;  bus_b.DATA_IN = din;  bus_b.CLR = clr;
    endtask

    task automatic ra_a(input int p, input logic [3:0] a);
        bus_a.RA[p*4 +: 4] = a;
    endtask

    task automatic ra_b(input int p, input logic [3:0] a);
        bus_b.RA[p*4 +: 4] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_both(input logic [3:0] wa, input logic [31:0] din);
        drive(1'b1, wa, 4'hF, din, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        bus_a.RA = '0;
        bus_b.RA = '0;
        #1 reset = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) expect_rd(0, p, 32'h0, "reset_rd_a");
        for (int p = 0; p < 4; p++) expect_rd(1, p, 32'h0, "reset_rd_b");
        check_sb();

        // write attempted while reset held low must be lost
        drive(1'b1, 4'h1, 4'hF, 32'hFFFF_FFFF, 1'b0);
        ra_a(0, 4'h1);
        expect_rd(0, 0, 32'h0, "reset_bypass_suppressed");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h0, "reset_write_suppressed");
        check_sb();
        reset = 1'b1;

        for (int a = 0; a < 16; a++) begin
            ra_a(0, 4'(a));
            ra_a(1, 4'(a));
            expect_rd(0, 0, 32'h0, "read_all_a_p0");
            expect_rd(0, 1, 32'h0, "read_all_a_p1");
            check_sb();
        end
        for (int a = 0; a < 12; a++) begin
            for (int p = 0; p < 4; p++) begin
                ra_b(p, 4'(a));
                expect_rd(1, p, 32'h0, "read_all_b");
            end
            check_sb();
        end

        write_both(4'd3, 32'hDEAD_BEEF);
        ra_a(0, 4'd3);
        ra_b(0, 4'd3);
        expect_rd(0, 0, 32'hDEAD_BEEF, "r3_written_a");
        expect_rd(1, 0, 32'hDEAD_BEEF, "r3_written_b");
        check_sb();
        drive(1'b1, 4'd3, 4'hF, 32'h5555_5555, 1'b1);
        expect_rd(0, 0, 32'h0, "clr_bypass_zero_a");
        expect_rd(1, 0, 32'hDEAD_BEEF, "clr_nobypass_stored_b");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h0, "clr_over_we_a");
        expect_rd(1, 0, 32'h0, "clr_over_we_b");
        check_sb();

        write_both(4'd5, 32'h1122_3344);
        ra_a(0, 4'd5);
        ra_b(0, 4'd5);
        drive(1'b1, 4'd5, 4'b0101, 32'hAABB_CCDD, 1'b0);
        expect_rd(0, 0, 32'h11BB_33DD, "be_bypass_merge_a");
        expect_rd(1, 0, 32'h1122_3344, "be_pre_edge_b");
        check_sb();
        tick();
        expect_rd(0, 0, 32'h11BB_33DD, "be_merge_a");
        expect_rd(1, 0, 32'h11BB_33DD, "be_merge_b");
        check_sb();
        drive(1'b1, 4'd5, 4'h0, 32'hFFFF_FFFF, 1'b0);
        expect_rd(0, 0, 32'h11BB_33DD, "be_zero_bypass_a");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h11BB_33DD, "be_zero_a");
        expect_rd(1, 0, 32'h11BB_33DD, "be_zero_b");
        check_sb();

        ra_a(0, 4'd2);
        ra_a(1, 4'd2);
        ra_b(0, 4'd2);
        drive(1'b1, 4'd2, 4'hF, 32'h1234_5678, 1'b0);
        expect_rd(0, 0, 32'h1234_5678, "bypass_same_cycle_p0");
        expect_rd(0, 1, 32'h1234_5678, "bypass_same_cycle_p1");
        expect_rd(1, 0, 32'h0, "nobypass_old_value");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h1234_5678, "bypass_after_edge");
        expect_rd(1, 0, 32'h1234_5678, "nobypass_after_edge");
        check_sb();

        ra_a(0, 4'd0);
        ra_b(0, 4'd0);
        drive(1'b1, 4'd0, 4'hF, 32'hFFFF_FFFF, 1'b0);
        expect_rd(0, 0, 32'hFFFF_FFFF, "r0_bypass_a");
        expect_rd(1, 0, 32'h0, "zero_reg_pre_edge_b");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'hFFFF_FFFF, "r0_written_a");
        expect_rd(1, 0, 32'h0, "zero_reg_b");
        check_sb();

        write_both(4'd11, 32'h0000_AAAA);
        ra_a(0, 4'd13);
        ra_b(0, 4'd13);
        ra_b(1, 4'd14);
        ra_b(2, 4'd11);
        ra_b(3, 4'd12);
        drive(1'b1, 4'd13, 4'hF, 32'h7777_7777, 1'b0);
        expect_rd(0, 0, 32'h7777_7777, "r13_bypass_a");
        expect_rd(1, 0, 32'h0, "range_ra13_pre_b");
        expect_rd(1, 2, 32'h0000_AAAA, "range_r11_pre_b");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h7777_7777, "r13_written_a");
        expect_rd(1, 0, 32'h0, "range_ra13_b");
        expect_rd(1, 1, 32'h0, "range_ra14_b");
        expect_rd(1, 2, 32'h0000_AAAA, "range_r11_kept_b");
        expect_rd(1, 3, 32'h0, "range_ra12_b");
        check_sb();
        ra_b(0, 4'd5);
        expect_rd(1, 0, 32'h11BB_33DD, "range_no_alias_r5_b");
        check_sb();

        write_both(4'd9, 32'h0BAD_C0DE);
        for (int p = 0; p < 4; p++) begin
            ra_b(p, 4'd9);
            expect_rd(1, p, 32'h0BAD_C0DE, "multi_same_addr");
        end
        check_sb();
        write_both(4'd1, 32'h1111_1111);
        write_both(4'd4, 32'h4444_4444);
        write_both(4'd6, 32'h6666_6666);
        write_both(4'd8, 32'h8888_8888);
        ra_b(0, 4'd1);
        ra_b(1, 4'd4);
        ra_b(2, 4'd6);
        ra_b(3, 4'd8);
        ra_a(0, 4'd4);
        ra_a(1, 4'd8);
        expect_rd(1, 0, 32'h1111_1111, "multi_r1");
        expect_rd(1, 1, 32'h4444_4444, "multi_r4");
        expect_rd(1, 2, 32'h6666_6666, "multi_r6");
        expect_rd(1, 3, 32'h8888_8888, "multi_r8");
        expect_rd(0, 0, 32'h4444_4444, "multi_a_r4");
        expect_rd(0, 1, 32'h8888_8888, "multi_a_r8");
        check_sb();

        write_both(4'd7, 32'hCAFE_F00D);
        ra_a(0, 4'd7);
        ra_a(1, 4'd7);
        ra_b(0, 4'd7);
        ra_b(1, 4'd5);
        expect_rd(0, 0, 32'hCAFE_F00D, "r7_written_a");
        expect_rd(1, 0, 32'hCAFE_F00D, "r7_written_b");
        check_sb();
        drive(1'b1, 4'd7, 4'hF, 32'h1212_1212, 1'b0);
        #2 reset = 1'b0;
        expect_rd(0, 0, 32'h0, "async_reset_a_p0");
        expect_rd(0, 1, 32'h0, "async_reset_a_p1");
        expect_rd(1, 0, 32'h0, "async_reset_b_r7");
        expect_rd(1, 1, 32'h0, "async_reset_b_r5");
        check_sb();
        tick();
        expect_rd(0, 0, 32'h0, "write_lost_in_reset_a");
        expect_rd(1, 0, 32'h0, "write_lost_in_reset_b");
        check_sb();
        reset = 1'b1;
        drive(1'b1, 4'd7, 4'hF, 32'h0000_0001, 1'b0);
        expect_rd(0, 0, 32'h0000_0001, "post_reset_bypass_a");
        expect_rd(1, 0, 32'h0, "post_reset_pre_edge_b");
        check_sb();
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        expect_rd(0, 0, 32'h0000_0001, "post_reset_write_a");
        expect_rd(1, 0, 32'h0000_0001, "post_reset_write_b");
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
